blob_frame_ctrl: RTL and testbench
==================================

BLOB_FRAME_CTRL -- requirements
Module: blob_frame_ctrl

Interface
REQ-001 Parameter IMG_COL, 640, pixels per line.
REQ-002 Parameter IMG_ROW, 480, lines per frame.
REQ-003 Parameter CLR_CYCLES, 4, length in cycles of the blob-engine clear pulse.
REQ-004 Parameter DRAIN_MAX, 4096, cycles to wait for the blob result before timeout.
REQ-005 i_clk  in  1  single clock; all logic rising-edge.
REQ-006 i_rst  in  1  reset, synchronous, active-high.
REQ-007 i_start  in  1  arm one frame, pulse.
REQ-008 i_sof  in  1  start-of-frame marker, coincident with first pixel.
REQ-009 i_pix_valid  in  1  binarized pixel strobe.
REQ-010 i_pix_bin  in  1  binarized pixel value.
REQ-011 o_blob_rst  out  1  clear to blob engine; the top level ORs it with i_rst.
REQ-012 o_blob_valid  out  1  pixel strobe to blob engine.
REQ-013 o_blob_seq  out  1  pixel bit to blob engine.
REQ-014 i_blob_valid  in  1  blob engine result-valid.
REQ-015 i_blob_count  in  8  blob engine component count.
REQ-016 o_count  out  8  latched blob count of the last completed frame.
REQ-017 o_done  out  1  one-cycle pulse when o_count updates.
REQ-018 o_busy  out  1  high in every state except IDLE.
REQ-019 o_err  out  1  sticky: early SOF detected mid-frame.
REQ-020 o_timeout  out  1  sticky: blob result not returned within DRAIN_MAX.

Function
REQ-021 The FSM SHALL have states IDLE, CLEAR, WAIT_SOF, STREAM and DRAIN.
REQ-022 In IDLE, i_start SHALL move the FSM to CLEAR and clear o_err and o_timeout; i_start in any other state SHALL be ignored.
REQ-023 In CLEAR, o_blob_rst SHALL be high for exactly CLR_CYCLES consecutive cycles, then the FSM SHALL enter WAIT_SOF.
REQ-024 In WAIT_SOF, pixels without i_sof SHALL be dropped; a pixel with i_pix_valid&i_sof SHALL be forwarded, the pixel counter SHALL load 1, and the FSM SHALL enter STREAM.
REQ-025 Forwarding SHALL be registered: o_blob_valid and o_blob_seq equal the previous-cycle i_pix_valid and i_pix_bin (1-cycle latency); o_blob_valid SHALL be 0 outside accepted pixels.
REQ-026 In STREAM, each i_pix_valid SHALL be forwarded and increment the 19-bit pixel counter; gap cycles SHALL hold the counter.
REQ-027 Acceptance of pixel number IMG_COL*IMG_ROW SHALL move the FSM to DRAIN on the same edge; later pixels SHALL NOT be forwarded.
REQ-028 i_sof with i_pix_valid in STREAM before the frame completes SHALL set o_err, SHALL NOT be forwarded, and SHALL move the FSM to CLEAR (automatic re-arm).
REQ-029 In DRAIN, i_blob_valid SHALL latch i_blob_count into o_count, pulse o_done for 1 cycle, and return the FSM to IDLE.
REQ-030 If DRAIN_MAX cycles pass in DRAIN without i_blob_valid, the block SHALL set o_timeout, leave o_count unchanged, not pulse o_done, and return to IDLE.
REQ-031 i_blob_valid outside DRAIN SHALL be ignored.
REQ-032 o_count SHALL hold its value until the next o_done.

Reset
REQ-033 i_rst SHALL force IDLE and zero the pixel and drain counters, o_blob_rst, o_blob_valid, o_blob_seq, o_count, o_done, o_busy, o_err and o_timeout on the next edge.
REQ-034 Reset mid-frame SHALL abandon the frame; the next i_start SHALL run a complete clean sequence.

Structure
REQ-035 Package blob_pkg SHALL hold IMG_COL, IMG_ROW, PIX_TOTAL, the pixel-counter width (19), the count width (8) and the FSM state enum.
REQ-036 A single sub-module blob_pix_cnt (load, increment, terminal-count flag) SHALL be used; all other logic SHALL be flat.

Verification (IMG_COL=8, IMG_ROW=4, CLR_CYCLES=4, DRAIN_MAX=16)
REQ-037 Scenario: i_start, then SOF plus 32 contiguous pixels, then blob returns count 5 -> o_blob_rst high for exactly 4 cycles; o_blob_valid high for 32 cycles, 1 cycle behind input; o_count=5; one o_done pulse; o_busy=0 on the following cycle.
REQ-038 Scenario: 32 pixels with 50% random valid gaps -> exactly 32 forwarded, bit-exact order; extra pixels after the 32nd are not forwarded.
REQ-039 Scenario: 5 pixels before SOF in WAIT_SOF -> none forwarded; the counter starts at the SOF pixel.
REQ-040 Scenario: second SOF at pixel 20 -> o_err=1, o_blob_rst reasserted for 4 cycles, then a clean re-sync on the next SOF.
REQ-041 Scenario: i_blob_valid withheld -> o_timeout=1 after 16 DRAIN cycles, no o_done, FSM in IDLE, o_count unchanged.
REQ-042 Scenario: i_rst at pixel 10 -> all outputs 0 on the next edge; a subsequent i_start completes a frame normally.

Source files
------------

// File: rtl/blob_pkg.sv
// Shared frame geometry, counter widths and controller state encoding for the blob front end.
package blob_pkg;

    localparam int IMG_COL   = 640;
    localparam int IMG_ROW   = 480;
    localparam int PIX_TOTAL = IMG_COL * IMG_ROW;
    localparam int PIX_W     = 19;
    localparam int CNT_W     = 8;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CLEAR,
        ST_WAIT_SOF,
        ST_STREAM,
        ST_DRAIN
    } state_t;

endpackage

// File: rtl/blob_pix_cnt.sv
// Accepted-pixel counter: load to 1 on the SOF pixel, increment per pixel.
// 'last' flags that the next accepted pixel completes the frame.
module blob_pix_cnt
    import blob_pkg::*;
#(
    parameter int TOTAL = PIX_TOTAL
) (
    input  logic clk,
    input  logic rst,
    input  logic load,
    input  logic inc,
    output logic last
);

    localparam logic [PIX_W-1:0] LAST_VAL = PIX_W'(TOTAL - 1);

    logic [PIX_W-1:0] count;

    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (load) begin
            count <= PIX_W'(1);
        end else if (inc) begin
            count <= count + 1'b1;
        end
    end

    assign last = (count == LAST_VAL);

endmodule

// File: rtl/blob_frame_ctrl.sv
// Arms the blob engine for one frame: clear pulse, SOF sync, pixel forwarding, result capture.
// Pixels reach the engine one cycle after input; results wait at most DRAIN_MAX cycles.
module blob_frame_ctrl #(
    parameter int IMG_COL    = blob_pkg::IMG_COL,
    parameter int IMG_ROW    = blob_pkg::IMG_ROW,
    parameter int CLR_CYCLES = 4,
    parameter int DRAIN_MAX  = 4096
) (
    input  logic                       i_clk,
    input  logic                       i_rst,
    input  logic                       i_start,
    input  logic                       i_sof,
    input  logic                       i_pix_valid,
    input  logic                       i_pix_bin,
    output logic                       o_blob_rst,
    output logic                       o_blob_valid,
    output logic                       o_blob_seq,
    input  logic                       i_blob_valid,
    input  logic [blob_pkg::CNT_W-1:0] i_blob_count,
    output logic [blob_pkg::CNT_W-1:0] o_count,
    output logic                       o_done,
    output logic                       o_busy,
    output logic                       o_err,
    output logic                       o_timeout
);

    localparam int PIX_TOTAL = IMG_COL * IMG_ROW;
    localparam int CW        = $clog2(CLR_CYCLES + 1);
    localparam int DW        = $clog2(DRAIN_MAX + 1);
    localparam logic [CW-1:0] CLR_LAST   = CW'(CLR_CYCLES - 1);
    localparam logic [DW-1:0] DRAIN_LAST = DW'(DRAIN_MAX - 1);

    blob_pkg::state_t state, state_nxt;
    logic [CW-1:0] clr_cnt;
    logic [DW-1:0] drain_cnt;
    logic pix_last;
    logic cnt_load, cnt_inc, fwd, set_err, set_to, clr_flags, take_result;

    blob_pix_cnt #(.TOTAL(PIX_TOTAL)) u_pix_cnt (
        .clk  (i_clk),
        .rst  (i_rst),
        .load (cnt_load),
        .inc  (cnt_inc),
        .last (pix_last)
    );

    always_comb begin
        state_nxt   = state;
        cnt_load    = 1'b0;
        cnt_inc     = 1'b0;
        fwd         = 1'b0;
        set_err     = 1'b0;
        set_to      = 1'b0;
        clr_flags   = 1'b0;
        take_result = 1'b0;
        case (state)
            blob_pkg::ST_IDLE: begin
                if (i_start) begin
                    clr_flags = 1'b1;
                    state_nxt = blob_pkg::ST_CLEAR;
                end
            end
            blob_pkg::ST_CLEAR: begin
                if (clr_cnt == CLR_LAST) state_nxt = blob_pkg::ST_WAIT_SOF;
            end
            blob_pkg::ST_WAIT_SOF: begin
                if (i_pix_valid && i_sof) begin
                    fwd       = 1'b1;
                    cnt_load  = 1'b1;
                    state_nxt = (PIX_TOTAL == 1) ? blob_pkg::ST_DRAIN : blob_pkg::ST_STREAM;
                end
            end
            blob_pkg::ST_STREAM: begin
                // A new SOF before the frame completes means we lost sync: drop it and re-arm.
                if (i_pix_valid && i_sof) begin
                    set_err   = 1'b1;
                    state_nxt = blob_pkg::ST_CLEAR;
                end else if (i_pix_valid) begin
                    fwd     = 1'b1;
                    cnt_inc = 1'b1;
                    if (pix_last) state_nxt = blob_pkg::ST_DRAIN;
                end
            end
            blob_pkg::ST_DRAIN: begin
                if (i_blob_valid) begin
                    take_result = 1'b1;
                    state_nxt   = blob_pkg::ST_IDLE;
                end else if (drain_cnt == DRAIN_LAST) begin
                    set_to    = 1'b1;
                    state_nxt = blob_pkg::ST_IDLE;
                end
            end
            default: state_nxt = blob_pkg::ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state        <= blob_pkg::ST_IDLE;
            clr_cnt      <= '0;
            drain_cnt    <= '0;
            o_blob_valid <= 1'b0;
            o_blob_seq   <= 1'b0;
            o_count      <= '0;
            o_done       <= 1'b0;
            o_err        <= 1'b0;
            o_timeout    <= 1'b0;
        end else begin
            state        <= state_nxt;
            clr_cnt      <= (state == blob_pkg::ST_CLEAR && state_nxt == blob_pkg::ST_CLEAR)
                            ? clr_cnt + 1'b1 : '0;
            drain_cnt    <= (state == blob_pkg::ST_DRAIN && state_nxt == blob_pkg::ST_DRAIN)
                            ? drain_cnt + 1'b1 : '0;
            o_blob_valid <= fwd;
            o_blob_seq   <= fwd & i_pix_bin;
            o_done       <= take_result;
            if (take_result) o_count <= i_blob_count;
            if (clr_flags) begin
                o_err     <= 1'b0;
                o_timeout <= 1'b0;
            end
            if (set_err) o_err <= 1'b1;
            if (set_to) o_timeout <= 1'b1;
        end
    end

    // Engine clear is decoded from state; the system top ORs it with the global reset.
    assign o_blob_rst = (state == blob_pkg::ST_CLEAR);
    assign o_busy     = (state != blob_pkg::ST_IDLE);

endmodule

// File: tb/tb_blob_frame_ctrl.sv
// Directed-random bench for blob_frame_ctrl on an 8x4 frame with a 16-cycle drain limit.
module tb_blob_frame_ctrl;

    localparam int TOT = 32;

    logic       clk = 1'b0;
    logic       rst, start, sof, pix_valid, pix_bin;
    logic       blob_rst, blob_valid, blob_seq;
    logic       eng_valid;
    logic [7:0] eng_count;
    logic [7:0] count;
    logic       done, busy, err, timeout;

    int errs = 0;
    int checks = 0;

    bit sv[256], ss[256], sb[256], ev[256];
    int n_st;
    int exp_taken;
    logic [7:0] last_count;

    always #5 clk = ~clk;

    blob_frame_ctrl #(
        .IMG_COL(8), .IMG_ROW(4), .CLR_CYCLES(4), .DRAIN_MAX(16)
    ) dut (
        .i_clk(clk), .i_rst(rst), .i_start(start), .i_sof(sof),
        .i_pix_valid(pix_valid), .i_pix_bin(pix_bin),
        .o_blob_rst(blob_rst), .o_blob_valid(blob_valid), .o_blob_seq(blob_seq),
        .i_blob_valid(eng_valid), .i_blob_count(eng_count),
        .o_count(count), .o_done(done), .o_busy(busy), .o_err(err), .o_timeout(timeout)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic put(input bit v, input bit s, input bit b);
        sv[n_st] = v; ss[n_st] = s; sb[n_st] = b;
        n_st++;
    endtask

    task automatic all_zero(input string tag);
        chk({tag, "_blob_rst"}, blob_rst, 0);
        chk({tag, "_blob_valid"}, blob_valid, 0);
        chk({tag, "_blob_seq"}, blob_seq, 0);
        chk({tag, "_count"}, count, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_err"}, err, 0);
        chk({tag, "_timeout"}, timeout, 0);
    endtask

    // Pulse start and measure how long the engine clear stays asserted.
    task automatic do_start();
        start = 1'b1;
        tick();
        start = 1'b0;
        count_clear("clr_len");
    endtask

    task automatic count_clear(input string tag);
        int n = 0;
        while (blob_rst === 1'b1 && n < 20) begin
            n++;
            tick();
        end
        chk(tag, n, 4);
    endtask

    // Frame: 'pre' non-SOF pixels, SOF, then valid pixels up to npix (optionally with gaps),
    // an optional early SOF, then 'extra' trailing pixels.
    task automatic run_frame(input int pre, input bit gaps, input int npix,
                             input int extra, input bit sof_end);
        int  vcnt, taken, obs;
        bit  started, aborted;
        n_st = 0;
        for (int i = 0; i < pre; i++) put(1'b1, 1'b0, 1'($urandom_range(0, 1)));
        put(1'b1, 1'b1, 1'($urandom_range(0, 1)));
        vcnt = 1;
        while (vcnt < npix && n_st < 200) begin
            if (gaps && $urandom_range(0, 1) == 1)
                put(1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            else begin
                put(1'b1, 1'b0, 1'($urandom_range(0, 1)));
                vcnt++;
            end
        end
        if (sof_end) put(1'b1, 1'b1, 1'($urandom_range(0, 1)));
        for (int i = 0; i < extra; i++) put(1'b1, 1'b0, 1'($urandom_range(0, 1)));

        // Reference: drop until the first SOF pixel, then forward valid pixels until the
        // frame total; an SOF before that aborts forwarding.
        started = 1'b0; aborted = 1'b0; taken = 0;
        for (int i = 0; i < n_st; i++) begin
            ev[i] = 1'b0;
            if (sv[i] && !aborted) begin
                if (!started) begin
                    if (ss[i]) begin ev[i] = 1'b1; started = 1'b1; taken = 1; end
                end else if (taken < TOT) begin
                    if (ss[i]) aborted = 1'b1;
                    else begin ev[i] = 1'b1; taken++; end
                end
            end
        end
        exp_taken = taken;

        obs = 0;
        for (int i = 0; i <= n_st; i++) begin
            if (i < n_st) begin
                pix_valid = sv[i]; sof = ss[i]; pix_bin = sb[i];
            end else begin
                pix_valid = 1'b0; sof = 1'b0; pix_bin = 1'b0;
            end
            if (i > 0) begin
                chk("fwd_valid", blob_valid, ev[i-1]);
                if (ev[i-1]) chk("fwd_bit", blob_seq, sb[i-1]);
                if (blob_valid === 1'b1) obs++;
            end
            if (i < n_st) tick();
        end
        chk("fwd_total", obs, exp_taken);
    endtask

    task automatic finish_frame(input logic [7:0] c);
        chk("drain_busy", busy, 1);
        eng_valid = 1'b1;
        eng_count = c;
        tick();
        eng_valid = 1'b0;
        eng_count = 8'hEE;
        chk("done_pulse", done, 1);
        chk("count_latch", count, c);
        chk("busy_after", busy, 0);
        tick();
        chk("done_single", done, 0);
        chk("count_hold", count, c);
        last_count = c;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] c;
        int  n;
        bit  done_seen;
        rst = 1'b1; start = 1'b0; sof = 1'b0; pix_valid = 1'b0; pix_bin = 1'b0;
        eng_valid = 1'b0; eng_count = 8'h00;
        tick(); tick();
        all_zero("reset");
        rst = 1'b0;
        tick();
        all_zero("post_reset");

        // Contiguous frame, result 5.
        do_start();
        chk("armed_busy", busy, 1);
        run_frame(0, 1'b0, TOT, 0, 1'b0);
        finish_frame(8'd5);

        // Engine result outside drain is ignored.
        eng_valid = 1'b1; eng_count = 8'd77;
        tick();
        eng_valid = 1'b0;
        chk("idle_result_done", done, 0);
        chk("idle_result_count", count, 5);

        // Start while busy is ignored; frame with random gaps and trailing pixels.
        do_start();
        start = 1'b1; tick(); start = 1'b0;
        run_frame(0, 1'b1, TOT, 6, 1'b0);
        c = 8'($urandom_range(1, 255));
        finish_frame(c);

        // Pixels before SOF are dropped.
        do_start();
        run_frame(5, 1'b0, TOT, 0, 1'b0);
        c = 8'($urandom_range(1, 255));
        finish_frame(c);

        // Early SOF at pixel 20: error, automatic re-clear, then clean re-sync.
        do_start();
        run_frame(0, 1'b0, 19, 0, 1'b1);
        chk("early_sof_err", err, 1);
        chk("early_sof_busy", busy, 1);
        count_clear("reclr_len");
        run_frame(0, 1'b1, TOT, 0, 1'b0);
        c = 8'($urandom_range(1, 255));
        finish_frame(c);
        chk("err_sticky", err, 1);

        // Withheld result: timeout after 16 drain cycles.
        do_start();
        chk("start_clears_err", err, 0);
        run_frame(0, 1'b0, TOT, 0, 1'b0);
        n = 0; done_seen = 1'b0;
        while (busy === 1'b1 && n < 40) begin
            if (done === 1'b1) done_seen = 1'b1;
            n++;
            tick();
        end
        chk("drain_len", n, 16);
        chk("timeout_set", timeout, 1);
        chk("timeout_no_done", done_seen, 0);
        chk("timeout_done_now", done, 0);
        chk("timeout_count", count, last_count);

        // Reset mid-frame at pixel 10, then a normal frame.
        do_start();
        chk("start_clears_to", timeout, 0);
        run_frame(0, 1'b0, 10, 0, 1'b0);
        chk("pre_rst_busy", busy, 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        all_zero("mid_rst");
        do_start();
        run_frame(0, 1'b1, TOT, 0, 1'b0);
        c = 8'($urandom_range(1, 255));
        finish_frame(c);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
